bcd_to_binary_seq: RTL and testbench

//  Sequential packed-BCD to unsigned binary converter; inverse of the team's binary-to-BCD converter.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_mac.sv | 28 ++
 rtl/bcd_to_binary_seq.sv | 144 ++++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD <-> binary converter family.
//   state_t        : converter FSM encoding (IDLE / CONV / DONE)
//   BCD_MAX_DIGIT  : largest legal BCD digit value
//   BCD_BASE       : radix of a BCD digit
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam int         BCD_BASE      = 10;

endpackage : bcd_pkg

// File: rtl/bcd_digit_mac.sv
// -----------------------------------------------------------------------------
// bcd_digit_mac
// Combinational Horner step for decimal conversion: y = a*10 + d.
// The multiply by ten is built as (a<<3)+(a<<1) so no multiplier is inferred.
// Arithmetic wraps modulo 2^OUT_W.
// Ports:
//   a  in  OUT_W  running accumulator
//   d  in  4      next decimal digit (zero-extended before the add)
//   y  out OUT_W  a*10 + d
// -----------------------------------------------------------------------------
module bcd_digit_mac #(
  parameter int OUT_W = 14
) (
  input  logic [OUT_W-1:0] a,
  input  logic [3:0]       d,
  output logic [OUT_W-1:0] y
);

  logic [OUT_W-1:0] a_x8;
  logic [OUT_W-1:0] a_x2;
  logic [OUT_W-1:0] d_ext;

  assign a_x8  = a << 3;
  assign a_x2  = a << 1;
  assign d_ext = OUT_W'(d);
  assign y     = a_x8 + a_x2 + d_ext;

endmodule : bcd_digit_mac

// File: rtl/bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_seq
// Sequential packed-BCD to unsigned binary converter. A DIGITS-digit word is
// accepted in IDLE, converted most-significant digit first at one digit per
// clock (acc = acc*10 + digit), and presented in DONE until taken downstream.
// Latency from accept edge to out_valid is exactly DIGITS clocks.
//
// Optional build macro BCD_DIGIT_CHECK_EN:
//   defined   : a digit > 9 sets a sticky error; the result is out_err=1 and
//               out_bin=0.
//   undefined : no checking, digits 10..15 are weighted as-is, out_err stays 0.
//
// Ports:
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous active-high reset
//   in_bcd     in   4*DIGITS  packed BCD, MSD in the top nibble
//   in_valid   in   1         in_bcd valid
//   in_ready   out  1         high only in IDLE
//   out_bin    out  OUT_W     binary result
//   out_err    out  1         invalid digit seen (check build only)
//   out_valid  out  1         result valid (DONE)
//   out_ready  in   1         downstream takes the result
// -----------------------------------------------------------------------------
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] in_bcd,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_W-1:0]    out_bin,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int SR_W  = 4 * DIGITS;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   shift_q, shift_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [OUT_W-1:0]  out_bin_q, out_bin_d;
  logic              out_err_q, out_err_d;

  logic [3:0]        top_digit;
  logic [OUT_W-1:0]  mac_y;
  logic              digit_bad;
  logic              err_now;
  logic              last_digit;

  assign top_digit = shift_q[SR_W-1 -: 4];

  bcd_digit_mac #(.OUT_W(OUT_W)) u_mac (
    .a (acc_q),
    .d (top_digit),
    .y (mac_y)
  );

`ifdef BCD_DIGIT_CHECK_EN
  assign digit_bad = (top_digit > BCD_MAX_DIGIT);
`else
  assign digit_bad = 1'b0;
`endif

  // Error including the digit being consumed this cycle, so the final
  // digit's check reaches the DONE outputs without an extra clock.
  assign err_now    = err_q | digit_bad;
  assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    out_bin_d = out_bin_q;
    out_err_d = out_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shift_d = in_bcd;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        acc_d   = mac_y;
        shift_d = shift_q << 4;
        cnt_d   = cnt_q + CNT_W'(1);
        err_d   = err_now;
        if (last_digit) begin
          out_bin_d = err_now ? '0 : mac_y;
          out_err_d = err_now;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        // Outputs are simply held; out_bin keeps its value after handoff.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      out_bin_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      out_bin_q <= out_bin_d;
      out_err_q <= out_err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_bin   = out_bin_q;
  assign out_err   = out_err_q;

endmodule : bcd_to_binary_seq

// File: tb/tb_bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_binary_seq
// Self-checking bench for bcd_to_binary_seq (DIGITS=4, OUT_W=14).
// Expected results come from a positional-weight model (sum of digit*10^k).
// Honours BCD_DIGIT_CHECK_EN the same way the design build does.
// -----------------------------------------------------------------------------
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 4;
  localparam int OUT_W  = 14;

  logic              clk;
  logic              rst;
  logic [15:0]       in_bcd;
  logic              in_valid;
  logic              in_ready;
  logic [OUT_W-1:0]  out_bin;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;

  int vectors;
  int miscompares;
  int cyc;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bcd    (in_bcd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bin   (out_bin),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0]      bcd;
    logic [OUT_W-1:0] bin;
    logic             err;
  } vec_t;

  // Reference: weight each nibble by its decimal position, wrap to OUT_W bits.
  function automatic void ref_model(input logic [15:0] bcd,
                                    output logic [OUT_W-1:0] bin,
                                    output logic err);
    int unsigned total;
    int unsigned d;
    bit          bad;
    total = 0;
    bad   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      d = (int'(bcd) >> (4 * k)) & 15;
      total += d * (10 ** k);
      if (d > 9) bad = 1'b1;
    end
    bin = total[OUT_W-1:0];
    err = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
    if (bad) begin
      bin = '0;
      err = 1'b1;
    end
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // One full transaction starting at a negedge. 'stall' cycles of out_ready=0
  // are applied once the result is up, checking it stays stable.
  task automatic do_word(input logic [15:0] bcd, input int stall,
                         input logic [OUT_W-1:0] exp_bin, input logic exp_err);
    int t;
    int lat;
    out_ready = (stall == 0);
    in_bcd    = bcd;
    in_valid  = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) timeout("accept");
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) timeout("result");
    chk("latency", lat, DIGITS);
    chk("out_bin", int'(out_bin), int'(exp_bin));
    chk("out_err", int'(out_err), int'(exp_err));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_bin", int'(out_bin), int'(exp_bin));
      chk("stall_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", int'(out_valid), 0);
    chk("idle_ready", int'(in_ready), 1);
    chk("bin_kept", int'(out_bin), int'(exp_bin));
    $display("word %h stall %0d -> bin %0d err %0d (expect %0d/%0d)",
             bcd, stall, out_bin, out_err, exp_bin, exp_err);
  endtask

  vec_t tbl[8];

  initial begin
    logic [OUT_W-1:0] eb;
    logic             ee;
    logic [15:0]      w;
    logic [15:0]      words[3];
    int               acc_cyc[3];
    int               t;

    vectors     = 0;
    miscompares = 0;

    tbl[0] = '{16'h1234, 14'd1234, 1'b0};
    tbl[1] = '{16'h9999, 14'd9999, 1'b0};
    tbl[2] = '{16'h0000, 14'd0,    1'b0};
    tbl[3] = '{16'h0001, 14'd1,    1'b0};
    tbl[4] = '{16'h9000, 14'd9000, 1'b0};
    tbl[5] = '{16'h0507, 14'd507,  1'b0};
    tbl[6] = '{16'h0042, 14'd42,   1'b0};
`ifdef BCD_DIGIT_CHECK_EN
    tbl[7] = '{16'h12A4, 14'd0,    1'b1};
`else
    tbl[7] = '{16'h12A4, 14'd1304, 1'b0};
`endif

    rst       = 1'b1;
    in_bcd    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bin",   int'(out_bin),   0);
    chk("rst_out_err",   int'(out_err),   0);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      do_word(tbl[i].bcd, 0, tbl[i].bin, tbl[i].err);
    end

    // Backpressure with junk in_valid traffic while busy
    in_bcd   = 16'h0507;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);                 // accepted at the edge just passed
    in_bcd = 16'h9876;              // must be ignored
    t = 0;
    while (!out_valid && t < 50) begin
      chk("busy_in_ready", int'(in_ready), 0);
      @(negedge clk);
      t++;
    end
    if (!out_valid) timeout("bp_result");
    for (int s = 0; s < 5; s++) begin
      in_bcd = 16'(16'h1111 * (s + 1));
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_bin", int'(out_bin), 507);
      chk("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_bin", int'(out_bin), 507);
    $display("backpressure word 0507 -> bin %0d", out_bin);

    // Reset two clocks into conversion
    in_bcd   = 16'h4321;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    for (int s = 0; s < 6; s++) begin
      chk("abort_no_valid", int'(out_valid), 0);
      @(negedge clk);
    end
    $display("reset mid-conversion of 4321 -> aborted");
    do_word(16'h0042, 0, 14'd42, 1'b0);

    // Back-to-back with in_valid held high
    words[0] = 16'h0815;
    words[1] = 16'h2024;
    words[2] = 16'h0099;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_bcd = words[i];
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) timeout("b2b_accept");
      acc_cyc[i] = cyc;
      @(negedge clk);
      t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!out_valid) timeout("b2b_result");
      ref_model(words[i], eb, ee);
      chk("b2b_bin", int'(out_bin), int'(eb));
      if (i > 0) begin
        chk("b2b_spacing_ok", int'((acc_cyc[i] - acc_cyc[i-1]) >= DIGITS + 2), 1);
      end
      $display("b2b word %h -> bin %0d", words[i], out_bin);
    end
    @(negedge clk);
    in_valid = 1'b0;
    // A fourth accept may have happened at the last edge; let it drain.
    repeat (DIGITS + 2) @(negedge clk);
    chk("b2b_drained_ready", int'(in_ready), 1);

    // Randomized words with random backpressure
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < DIGITS; k++) begin
        if ($urandom_range(0, 7) == 0) w[4*k +: 4] = 4'($urandom_range(10, 15));
        else                           w[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      ref_model(w, eb, ee);
      do_word(w, int'($urandom_range(0, 3)), eb, ee);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bcd_to_binary_seq
